// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, default clock/line rates and
// the bit-period derivation used by both receive and transmit paths.
// No ports; imported with import uart_pkg::*.
package uart_pkg;

  localparam int unsigned UART_CLK_HZ = 12000000;
  localparam int unsigned UART_BAUD   = 115200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } uart_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Phase count of the bit centre.
  function automatic int unsigned calc_mid(input int unsigned div);
    return div / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from input change (setup met) to q_o.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), d_i (async input), q_o (synced output).
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Purpose: 8N1 UART receiver with 3-sample majority vote and a one-entry output holding register.
// Latency: rx falling edge to valid_o = 2 + 9*DIV + M + 2 cycles (992 at 12 MHz / 115200).
// Backpressure: valid/ready; a good byte arriving while the holder is full and not being drained is dropped with overrun_o.
// Ports: clk, rst_n (async active-low), rx (raw pin, idle high), data_o/valid_o/ready_i (byte handshake),
//        frame_err_o, break_o, overrun_o (single-cycle status pulses).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = UART_CLK_HZ,
  parameter int unsigned BAUD   = UART_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       break_o,
  output logic       overrun_o
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned M    = calc_mid(DIV);
  localparam int          PH_W = $clog2(DIV);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(M - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(M);
  localparam logic [PH_W-1:0] PH_DEC  = PH_W'(M + 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e     state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [2:0]      idx_q, idx_d;
  logic            done_q, done_d;     // all 8 data bits decided, waiting for the wrap into STOP
  logic [7:0]      shreg_q, shreg_d;
  logic [1:0]      smp_q, smp_d;       // samples taken at phases M-1 and M
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            brk_q, brk_d;
  logic            ovr_q, ovr_d;

  logic            maj;
  logic            at_dec;
  logic            at_wrap;
  logic [PH_W-1:0] phase_adv;
  logic            good_byte;
  logic            consume;

  // Third sample is the live synced value at phase M+1.
  assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign at_dec    = (phase_q == PH_DEC);
  assign at_wrap   = (phase_q == PH_LAST);
  assign phase_adv = at_wrap ? '0 : phase_q + PH_W'(1);
  assign consume   = valid_q & ready_i;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    done_d    = done_q;
    shreg_d   = shreg_q;
    smp_d     = smp_q;
    ferr_d    = 1'b0;
    brk_d     = 1'b0;
    good_byte = 1'b0;

    if (phase_q == PH_S0) smp_d[0] = rx_s;
    if (phase_q == PH_S1) smp_d[1] = rx_s;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        idx_d   = '0;
        done_d  = 1'b0;
        if (!rx_s) state_d = START;
      end

      START: begin
        phase_d = phase_adv;
        if (at_dec) begin
          if (maj) begin
            state_d = IDLE;
            phase_d = '0;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
      end

      DATA: begin
        phase_d = phase_adv;
        if (at_dec) begin
          shreg_d = {maj, shreg_q[7:1]};
          if (idx_q == 3'd7) done_d = 1'b1;
          else               idx_d  = idx_q + 3'd1;
        end
        if (at_wrap && done_q) begin
          state_d = STOP;
          done_d  = 1'b0;
        end
      end

      STOP: begin
        phase_d = phase_adv;
        if (at_dec) begin
          phase_d = '0;
          // Good stop returns to IDLE at the bit centre so a start bit
          // immediately after the stop bit is not missed.
          if (maj) begin
            good_byte = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            brk_d   = (shreg_q == 8'h00);
            state_d = WAIT_HI;
          end
        end
      end

      WAIT_HI: begin
        phase_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Holding register: a new byte may replace the old one only in the
  // cycle the old one is being consumed.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (good_byte) begin
      if (!valid_q || consume) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      shreg_q <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      shreg_q <= shreg_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign break_o     = brk_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Purpose: self-checking bench for uart_rx_core at 12 MHz / 115200 8N1.
// Latency: expected delivery 992 cycles after the start-bit edge.
// Backpressure: ready_i driven per scenario.
module tb_uart_rx_core;

  localparam int BIT = 104;
  localparam int LAT = 992;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       frame_err_o;
  logic       break_o;
  logic       overrun_o;

  uart_rx_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .break_o     (break_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  logic [7:0] acc_q[$];
  int         vrise_t[$];
  int         ferr_t[$];
  int         brk_t[$];
  int         ovr_t[$];
  int         vhigh = 0;
  bit         prev_v = 1'b0;

  always @(negedge clk) begin
    if (valid_o && ready_i) acc_q.push_back(data_o);
    if (valid_o && !prev_v) vrise_t.push_back(cyc);
    if (valid_o) vhigh++;
    if (frame_err_o) ferr_t.push_back(cyc);
    if (break_o) brk_t.push_back(cyc);
    if (overrun_o) ovr_t.push_back(cyc);
    prev_v = valid_o;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    acc_q.delete();
    vrise_t.delete();
    ferr_t.delete();
    brk_t.delete();
    ovr_t.delete();
    vhigh = 0;
  endtask

  // Called just after a rising edge; drives v for n edges and returns just after the last.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // t0 = cycle stamp of the edge that captures the start-bit fall.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bc, output int t0);
    t0 = cyc + 1;
    hold(1'b0, bc);
    for (int i = 0; i < 8; i++) hold(b[i], bc);
    hold(stop_bit, bc);
  endtask

  function automatic int first_or(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  typedef struct {
    logic [7:0] dat;
    logic       stop_bit;
    int         exp_vld;
    int         exp_ferr;
    int         exp_brk;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0, t1;
    logic [7:0] exp_q[$];
    int exp_ferr, exp_brk;

    vecs[0] = '{8'hA5, 1'b1, 1, 0, 0};
    vecs[1] = '{8'h55, 1'b0, 0, 1, 0};
    vecs[2] = '{8'h12, 1'b1, 1, 0, 0};
    vecs[3] = '{8'h00, 1'b0, 0, 1, 1};
    vecs[4] = '{8'h00, 1'b1, 1, 0, 0};
    vecs[5] = '{8'hFF, 1'b1, 1, 0, 0};
    vecs[6] = '{8'h80, 1'b0, 0, 1, 0};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("reset_outputs", {data_o, valid_o, frame_err_o, break_o, overrun_o}, 64'h0);
    rst_n = 1'b1;
    hold(1'b1, 20);

    // Table-driven single frames, ready_i held high
    foreach (vecs[k]) begin
      clear_mon();
      send_frame(vecs[k].dat, vecs[k].stop_bit, BIT, t0);
      hold(1'b1, 300);
      chk($sformatf("vec%0d_nvalid", k), acc_q.size(), vecs[k].exp_vld);
      chk($sformatf("vec%0d_nferr", k), ferr_t.size(), vecs[k].exp_ferr);
      chk($sformatf("vec%0d_nbrk", k), brk_t.size(), vecs[k].exp_brk);
      chk($sformatf("vec%0d_novr", k), ovr_t.size(), 0);
      if (vecs[k].exp_vld != 0) begin
        chk($sformatf("vec%0d_data", k), (acc_q.size() > 0) ? acc_q[0] : 8'hxx, vecs[k].dat);
        chk($sformatf("vec%0d_lat", k), first_or(vrise_t) - t0, LAT);
        chk($sformatf("vec%0d_vhigh", k), vhigh, 1);
      end
      if (vecs[k].exp_ferr != 0)
        chk($sformatf("vec%0d_ferr_lat", k), first_or(ferr_t) - t0, LAT);
    end

    // Back-to-back frames with the consumer stalled
    clear_mon();
    ready_i = 1'b0;
    send_frame(8'h3C, 1'b1, BIT, t0);
    send_frame(8'hC3, 1'b1, BIT, t1);
    hold(1'b1, 200);
    chk("b2b_valid_held", valid_o, 1'b1);
    chk("b2b_data_held", data_o, 8'h3C);
    chk("b2b_novr", ovr_t.size(), 1);
    chk("b2b_ovr_lat", first_or(ovr_t) - t1, LAT);
    chk("b2b_first_lat", first_or(vrise_t) - t0, LAT);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    hold(1'b1, 3);
    chk("b2b_consumed", acc_q.size(), 1);
    chk("b2b_consumed_data", (acc_q.size() > 0) ? acc_q[0] : 8'hxx, 8'h3C);
    chk("b2b_valid_drop", valid_o, 1'b0);
    ready_i = 1'b1;

    // Short false start, then a real frame shortly after
    clear_mon();
    hold(1'b0, 30);
    hold(1'b1, 40);
    send_frame(8'h81, 1'b1, BIT, t1);
    hold(1'b1, 300);
    chk("glitch_nvalid", acc_q.size(), 1);
    chk("glitch_data", (acc_q.size() > 0) ? acc_q[0] : 8'hxx, 8'h81);
    chk("glitch_lat", first_or(vrise_t) - t1, LAT);
    chk("glitch_nferr", ferr_t.size(), 0);

    // Line held low for two frame times
    clear_mon();
    t0 = cyc + 1;
    hold(1'b0, 20 * BIT);
    chk("brk_nferr", ferr_t.size(), 1);
    chk("brk_nbrk", brk_t.size(), 1);
    chk("brk_ferr_lat", first_or(ferr_t) - t0, LAT);
    chk("brk_brk_lat", first_or(brk_t) - t0, LAT);
    hold(1'b1, 300);
    chk("brk_no_repeat", ferr_t.size() + brk_t.size(), 2);
    chk("brk_nvalid", acc_q.size(), 0);

    // Reset during data bit 4 of 0x99, then a clean 0x7E
    clear_mon();
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT);
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b1, 50);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_outputs", {data_o, valid_o, frame_err_o, break_o, overrun_o}, 64'h0);
    rst_n = 1'b1;
    hold(1'b1, 200);
    send_frame(8'h7E, 1'b1, BIT, t0);
    hold(1'b1, 300);
    chk("midrst_nvalid", acc_q.size(), 1);
    chk("midrst_data", (acc_q.size() > 0) ? acc_q[0] : 8'hxx, 8'h7E);
    chk("midrst_lat", first_or(vrise_t) - t0, LAT);
    chk("midrst_nerr", ferr_t.size() + brk_t.size() + ovr_t.size(), 0);

    // Randomized frames with baud skew, checked against a frame-level model
    clear_mon();
    exp_ferr = 0;
    exp_brk = 0;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] b;
      logic       ok;
      int         bc, gap;
      b   = 8'($urandom_range(0, 255));
      if (k % 5 == 4) b = 8'h00;
      ok  = ($urandom_range(0, 4) != 0);
      bc  = $urandom_range(BIT - 2, BIT + 2);
      gap = ok ? $urandom_range(0, 150) : $urandom_range(2 * bc, 400);
      if (ok) begin
        exp_q.push_back(b);
      end else begin
        exp_ferr++;
        if (b == 8'h00) exp_brk++;
      end
      send_frame(b, ok, bc, t0);
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, 300);
    chk("rand_nbytes", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rand_byte%0d", i), (i < acc_q.size()) ? acc_q[i] : 8'hxx, exp_q[i]);
    chk("rand_nferr", ferr_t.size(), exp_ferr);
    chk("rand_nbrk", brk_t.size(), exp_brk);
    chk("rand_novr", ovr_t.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
